// File: rtl/frame_buf_ctrl_if.sv
// Pixel-source / display-sink handshake and frame-buffer strobes for frame_buf_ctrl.
// The testbench drives through the master modport, and the controller uses the slave modport.
interface frame_buf_ctrl_if #(
  parameter int unsigned IDX_WIDTH = 4
) ();
  logic                 wr_valid_in;
  logic                 wr_sof_in;
  logic                 rd_req_in;
  logic                 wr_en_out;
  logic [IDX_WIDTH:0]   wr_addr_out;
  logic                 rd_en_out;
  logic [IDX_WIDTH:0]   rd_addr_out;
  logic                 rd_valid_out;
  logic                 wr_stall_out;
  logic                 frame_repeat_out;
  logic                 frame_drop_out;

  modport master (
    output wr_valid_in, wr_sof_in, rd_req_in,
    input  wr_en_out, wr_addr_out, rd_en_out, rd_addr_out, rd_valid_out,
           wr_stall_out, frame_repeat_out, frame_drop_out
  );

  modport slave (
    input  wr_valid_in, wr_sof_in, rd_req_in,
    output wr_en_out, wr_addr_out, rd_en_out, rd_addr_out, rd_valid_out,
           wr_stall_out, frame_repeat_out, frame_drop_out
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Ping-pong scheduler for a two-bank frame buffer. The writer fills one bank while the reader
// scans the other. Banks swap only at read-frame boundaries.
module frame_buf_ctrl #(
  parameter int unsigned FRAME_PIXELS = 16,
  parameter int unsigned IDX_WIDTH    = 4
) (
  input logic             clk,
  input logic             reset,
  frame_buf_ctrl_if.slave bus
);

  localparam logic [0:0] StEmpty  = 1'b0;
  localparam logic [0:0] StActive = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(FRAME_PIXELS - 1);

  logic [0:0]           state_q, state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [IDX_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                 wr_full_q, wr_full_d;
  logic                 wr_en_q, wr_en_d;
  logic [IDX_WIDTH:0]   wr_addr_q, wr_addr_d;
  logic                 rd_en_q, rd_en_d;
  logic [IDX_WIDTH:0]   rd_addr_q, rd_addr_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_stall_q, wr_stall_d;
  logic                 frame_repeat_q, frame_repeat_d;
  logic                 frame_drop_q, frame_drop_d;

  logic                 wr_accept, sof_hit, wr_last;
  logic                 rd_issue, rd_last, frame_ready, swap;
  logic [IDX_WIDTH-1:0] wr_idx_eff;

  always_comb begin
    wr_accept   = bus.wr_valid_in && !wr_full_q;
    sof_hit     = bus.wr_sof_in && !wr_full_q;
    wr_idx_eff  = sof_hit ? '0 : wr_idx_q;
    wr_last     = wr_accept && (wr_idx_eff == LastIdx);
    rd_issue    = (state_q == StActive) && bus.rd_req_in;
    rd_last     = rd_issue && (rd_idx_q == LastIdx);
    // A frame finishing on this very edge counts as ready, so a coincident boundary never stalls.
    frame_ready = wr_full_q || wr_last;
    swap        = frame_ready && ((state_q == StEmpty) || rd_last);
  end

  always_comb begin
    state_d   = swap ? StActive : state_q;
    wr_bank_d = swap ? ~wr_bank_q : wr_bank_q;
    rd_bank_d = swap ? wr_bank_q : rd_bank_q;

    wr_idx_d = wr_idx_q;
    if (sof_hit) begin
      wr_idx_d = '0;
    end
    if (wr_accept) begin
      wr_idx_d = wr_last ? '0 : wr_idx_eff + IDX_WIDTH'(1);
    end

    wr_full_d = (wr_full_q || wr_last) && !swap;

    rd_idx_d = rd_idx_q;
    if (rd_issue) begin
      rd_idx_d = rd_last ? '0 : rd_idx_q + IDX_WIDTH'(1);
    end

    wr_en_d        = !wr_accept;
    wr_addr_d      = wr_accept ? {wr_bank_q, wr_idx_eff} : wr_addr_q;
    rd_en_d        = !rd_issue;
    rd_addr_d      = rd_issue ? {rd_bank_q, rd_idx_q} : rd_addr_q;
    rd_valid_d     = !rd_en_q;
    wr_stall_d     = wr_full_d;
    frame_repeat_d = rd_last && !frame_ready;
    frame_drop_d   = sof_hit && (wr_idx_q != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StEmpty;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b1;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      wr_full_q      <= 1'b0;
      wr_en_q        <= 1'b1;
      wr_addr_q      <= '0;
      rd_en_q        <= 1'b1;
      rd_addr_q      <= {1'b1, {IDX_WIDTH{1'b0}}};
      rd_valid_q     <= 1'b0;
      wr_stall_q     <= 1'b0;
      frame_repeat_q <= 1'b0;
      frame_drop_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      wr_full_q      <= wr_full_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      rd_valid_q     <= rd_valid_d;
      wr_stall_q     <= wr_stall_d;
      frame_repeat_q <= frame_repeat_d;
      frame_drop_q   <= frame_drop_d;
    end
  end

  assign bus.wr_en_out        = wr_en_q;
  assign bus.wr_addr_out      = wr_addr_q;
  assign bus.rd_en_out        = rd_en_q;
  assign bus.rd_addr_out      = rd_addr_q;
  assign bus.rd_valid_out     = rd_valid_q;
  assign bus.wr_stall_out     = wr_stall_q;
  assign bus.frame_repeat_out = frame_repeat_q;
  assign bus.frame_drop_out   = frame_drop_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl: per-cycle expected strobes/addresses go through a queue
// scoreboard and are checked with immediate assertions one clock after being driven.
module tb_frame_buf_ctrl;
  localparam int unsigned FP = 16;
  localparam int unsigned IW = 4;

  typedef struct packed {
    logic        en;
    logic [IW:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t wq[$];
  exp_t rq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic prev_re  = 1'b0;

  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.IDX_WIDTH(IW)) bus ();

  frame_buf_ctrl #(.FRAME_PIXELS(FP), .IDX_WIDTH(IW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".wr_en"},    32'(bus.wr_en_out),        32'd1);
    check({tag, ".wr_addr"},  32'(bus.wr_addr_out),      32'h00);
    check({tag, ".rd_en"},    32'(bus.rd_en_out),        32'd1);
    check({tag, ".rd_addr"},  32'(bus.rd_addr_out),      32'h10);
    check({tag, ".rd_valid"}, 32'(bus.rd_valid_out),     32'd0);
    check({tag, ".stall"},    32'(bus.wr_stall_out),     32'd0);
    check({tag, ".repeat"},   32'(bus.frame_repeat_out), 32'd0);
    check({tag, ".drop"},     32'(bus.frame_drop_out),   32'd0);
  endtask

  task automatic flags(input logic stall, input logic rep, input logic drop);
    check("wr_stall",     32'(bus.wr_stall_out),     32'(stall));
    check("frame_repeat", 32'(bus.frame_repeat_out), 32'(rep));
    check("frame_drop",   32'(bus.frame_drop_out),   32'(drop));
  endtask

  // One clock: drive inputs, queue the expected strobes, then compare just after the edge.
  task automatic cyc(input logic v, input logic sof, input logic req,
                     input logic we, input logic [IW:0] wa,
                     input logic re, input logic [IW:0] ra);
    exp_t w;
    exp_t r;
    bus.wr_valid_in = v;
    bus.wr_sof_in   = sof;
    bus.rd_req_in   = req;
    wq.push_back({we, wa});
    rq.push_back({re, ra});
    @(posedge clk);
    #1;
    w = wq.pop_front();
    r = rq.pop_front();
    check("wr_en", 32'(bus.wr_en_out), 32'(!w.en));
    if (w.en) check("wr_addr", 32'(bus.wr_addr_out), 32'(w.addr));
    check("rd_en", 32'(bus.rd_en_out), 32'(!r.en));
    if (r.en) check("rd_addr", 32'(bus.rd_addr_out), 32'(r.addr));
    check("rd_valid", 32'(bus.rd_valid_out), 32'(prev_re));
    prev_re = r.en;
  endtask

  initial begin
    bus.wr_valid_in = 1'b0;
    bus.wr_sof_in   = 1'b0;
    bus.rd_req_in   = 1'b0;
    reset           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;

    // Reads are ignored until the first frame is complete.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00);

    // First frame into bank 0, then swap.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'(i), 1'b0, 5'h00);
      flags(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00);

    // Steady read of bank 0 with no second frame: repeat at the boundary.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 5'(i));
      flags(1'b0, i == 15, 1'b0);
    end

    // Reader to idx 5, then a full write frame into bank 1 stalls the writer.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 5'(i));
      flags(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'(16 + i), 1'b0, 5'h00);
      flags(i == 15, 1'b0, 1'b0);
    end
    repeat (2) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00);
      flags(1'b1, 1'b0, 1'b0);
    end
    for (int i = 6; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 5'(i));
      flags(i != 15, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'h00, 1'b1, 5'h10);
    flags(1'b0, 1'b0, 1'b0);

    // Coincident final write and final read: swap with no stall and no repeat.
    for (int i = 1; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'(i), 1'b1, 5'(16 + i));
      flags(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'h10, 1'b1, 5'h00);
    flags(1'b0, 1'b0, 1'b0);

    // Resync: sof alone at idx 7, then sof with a pixel at idx 1.
    for (int i = 1; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'(16 + i), 1'b0, 5'h00);
      flags(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00);
    flags(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'h10, 1'b0, 5'h00);
    flags(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'h10, 1'b0, 5'h00);
    flags(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'h11, 1'b0, 5'h00);
    flags(1'b0, 1'b0, 1'b0);

    // Read bank 0 up to idx 9, then assert reset between clock edges.
    for (int i = 1; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 5'(i));
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    bus.rd_req_in = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    prev_re = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'h00, 1'b0, 5'h00);
    flags(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
- Single-clock ping-pong scheduler for the 24-bit frame buffer.
- Treats the buffer as two banks of FRAME_PIXELS words. The pixel source fills one bank while the display sink reads the other.
- Generates active-low write/read enables and bank-qualified addresses.
- Swaps banks only at read-frame boundaries. Reports repeated frames (source late) and writer stalls/drops (source early).

Parameters:
FRAME_PIXELS, 16, pixels per frame (>=2)
IDX_WIDTH, 4, pixel index width; 2**IDX_WIDTH >= FRAME_PIXELS

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
wr_valid_in  input  1  source pixel strobe, one pixel per high cycle
wr_sof_in  input  1  source start-of-frame; resyncs write index
rd_req_in  input  1  sink pixel request
wr_en_out  output  1  frame buffer write enable, active-low
wr_addr_out  output  IDX_WIDTH+1  {wr_bank, wr_idx}
rd_en_out  output  1  frame buffer read enable, active-low
rd_addr_out  output  IDX_WIDTH+1  {rd_bank, rd_idx}
rd_valid_out  output  1  frame buffer read data valid (rd_en_out delayed 1 cycle)
wr_stall_out  output  1  write bank full, awaiting swap
frame_repeat_out  output  1  1-cycle pulse: read frame restarted on same bank
frame_drop_out  output  1  1-cycle pulse: partial frame discarded by wr_sof_in

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset). All outputs are registered.
- Reset values:
  - wr_en_out=1, rd_en_out=1.
  - wr_addr_out=0, rd_addr_out={1'b1,0}.
  - rd_valid_out=0, wr_stall_out=0, frame_repeat_out=0, frame_drop_out=0.
  - Internal: wr_bank=0, rd_bank=1, wr_idx=0, rd_idx=0, wr_full=0, state=EMPTY.
- Reset asserted mid-frame aborts both sides immediately and returns to reset values. Frame buffer contents are don't-care.
- Write path:
  - wr_valid_in=1 and wr_full=0 at edge N -> at N+1: wr_en_out=0, wr_addr_out={wr_bank, wr_idx}. wr_idx then increments.
  - Otherwise wr_en_out=1 next cycle.
  - Write of idx FRAME_PIXELS-1 sets wr_full and wraps wr_idx to 0.
- While wr_full=1:
  - wr_valid_in is ignored (pixels dropped).
  - wr_en_out=1 and wr_stall_out=1.
- wr_sof_in=1:
  - If wr_idx!=0 and wr_full=0: wr_idx<=0 and frame_drop_out pulses.
  - If wr_valid_in is also high that cycle, the pixel is written at idx 0 and wr_idx<=1.
  - Ignored while wr_full=1.
- State machine:
  - EMPTY: reads are suppressed. rd_req_in is ignored; rd_en_out=1, rd_valid_out=0. When wr_full is set (first complete frame), perform a swap and go to ACTIVE.
  - ACTIVE: rd_req_in=1 at edge N -> at N+1: rd_en_out=0, rd_addr_out={rd_bank, rd_idx}. rd_idx then increments. At N+2: rd_valid_out=1.
- Read boundary (read of idx FRAME_PIXELS-1 issued): rd_idx wraps to 0. Then:
  - If wr_full=1, or the final write of the write frame is accepted in the same cycle: swap.
  - Otherwise frame_repeat_out pulses and the same bank is re-read.
- Swap: rd_bank<=wr_bank, wr_bank<=~wr_bank, wr_full<=0, wr_stall_out<=0.
- Simultaneous final write and read boundary: swap occurs. wr_stall_out is never asserted, and a wr_valid_in in the next cycle writes idx 0 of the new bank.
- Bank invariant: wr_bank != rd_bank at all times; the read bank is never written.
- FRAME_PIXELS is not required to be a power of two; indices compare explicitly against FRAME_PIXELS-1.

Test Plan:
- Reset check: hold reset=0 -> all outputs at reset values. Release reset, drive rd_req_in=1 for 5 cycles with no writes -> rd_en_out stays 1, state EMPTY.
- First frame (FRAME_PIXELS=16): 16 consecutive wr_valid_in cycles -> wr_addr_out 0x00..0x0F with wr_en_out=0. Next cycle: rd_bank=0, wr_bank=1. Following writes show wr_addr_out=0x10.
- Steady read after first frame: rd_req_in held high -> rd_addr_out 0x00..0x0F, with rd_valid_out trailing rd_en_out by 1 cycle. If no second frame is complete at the boundary: frame_repeat_out pulses once and rd_addr_out returns to 0x00.
- Writer stall: complete a write frame into bank 1 while the reader is at idx 5 -> wr_stall_out=1 and further wr_valid_in produce no wr_en_out. At the read boundary: swap, rd_addr_out=0x10, wr_stall_out=0, and the next write goes to 0x00.
- Coincident boundary: final write (idx 15) and final read (idx 15) issued on the same edge -> swap, no stall, no repeat pulse. A write on the next cycle goes to the freed bank idx 0.
- Resync and reset: wr_sof_in at wr_idx=7 -> frame_drop_out pulses and the next write is at idx 0. Assert reset mid-read at idx 9 -> outputs return to reset values asynchronously, before the next clock edge.
